// File: rtl/vga_sync_core_if.sv
// ============================================================================
// Module      : vga_sync_core_if
// Description : Pixel-side bundle between the VGA timing core, the renderer
//               and the connector pins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_sync_core_if;
    logic [4:0]  rgb_r;
    logic [5:0]  rgb_g;
    logic [4:0]  rgb_b;
    logic        p_tick;
    logic [11:0] pixel_x;
    logic [11:0] pixel_y;
    logic        video_on;
    logic        frame_tick;
    logic        hsync_n;
    logic        vsync_n;
    logic [4:0]  vga_r;
    logic [5:0]  vga_g;
    logic [4:0]  vga_b;

    // Timing core side
    modport master (
        input  rgb_r, rgb_g, rgb_b,
        output p_tick, pixel_x, pixel_y, video_on, frame_tick,
        output hsync_n, vsync_n, vga_r, vga_g, vga_b
    );

    // Renderer / pin consumer side
    modport slave (
        output rgb_r, rgb_g, rgb_b,
        input  p_tick, pixel_x, pixel_y, video_on, frame_tick,
        input  hsync_n, vsync_n, vga_r, vga_g, vga_b
    );
endinterface

`default_nettype wire

// File: rtl/vga_sync_core.sv
// ============================================================================
// Module      : vga_sync_core
// Description : VGA pixel divider, H/V raster counters, sync and blanking.
//               Optional macro VGA_SYNC_OUT_REG_EN adds a one-pixel output
//               register on RGB and sync pins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_core #(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    vga_sync_core_if.master   vid
);
    localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] C_H_LAST  = 12'(H_TOTAL - 1);
    localparam logic [11:0] C_V_LAST  = 12'(V_TOTAL - 1);
    localparam logic [11:0] C_H_DISP  = 12'(H_DISPLAY);
    localparam logic [11:0] C_V_DISP  = 12'(V_DISPLAY);
    localparam logic [11:0] C_HS_FROM = 12'(H_DISPLAY + H_FP);
    localparam logic [11:0] C_HS_TO   = 12'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [11:0] C_VS_FROM = 12'(V_DISPLAY + V_FP);
    localparam logic [11:0] C_VS_TO   = 12'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic p_tick_w;

    generate
        if (CLK_DIV == 1) begin : g_div_bypass
            assign p_tick_w = 1'b1;
        end else begin : g_div
            localparam int DIV_W = $clog2(CLK_DIV);
            localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);
            logic [DIV_W-1:0] div_q, div_d;

            always_comb begin
                div_d = (div_q == C_DIV_LAST) ? '0 : div_q + DIV_W'(1);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) div_q <= '0;
                else        div_q <= div_d;
            end

            assign p_tick_w = (div_q == C_DIV_LAST);
        end
    endgenerate

    logic [11:0] x_q, x_d, y_q, y_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;

    // Syncs decode the next counter value so they update on the same edge
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (p_tick_w) begin
            if (x_q == C_H_LAST) begin
                x_d = '0;
                y_d = (y_q == C_V_LAST) ? '0 : y_q + 12'd1;
            end else begin
                x_d = x_q + 12'd1;
            end
        end
        hsync_d = !((x_d >= C_HS_FROM) && (x_d <= C_HS_TO));
        vsync_d = !((y_d >= C_VS_FROM) && (y_d <= C_VS_TO));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    logic       video_on_w;
    logic [4:0] r_gated_w, b_gated_w;
    logic [5:0] g_gated_w;

    assign video_on_w = (x_q < C_H_DISP) && (y_q < C_V_DISP);
    assign r_gated_w  = video_on_w ? vid.rgb_r : 5'd0;
    assign g_gated_w  = video_on_w ? vid.rgb_g : 6'd0;
    assign b_gated_w  = video_on_w ? vid.rgb_b : 5'd0;

    assign vid.p_tick     = p_tick_w;
    assign vid.pixel_x    = x_q;
    assign vid.pixel_y    = y_q;
    assign vid.video_on   = video_on_w;
    assign vid.frame_tick = p_tick_w && (x_q == C_H_LAST) && (y_q == C_V_LAST);

`ifdef VGA_SYNC_OUT_REG_EN
    // Colour and sync share one pixel of lag so they remain aligned at the pins
    logic [4:0] vga_r_q, vga_r_d, vga_b_q, vga_b_d;
    logic [5:0] vga_g_q, vga_g_d;
    logic       hs_out_q, hs_out_d, vs_out_q, vs_out_d;

    always_comb begin
        vga_r_d  = p_tick_w ? r_gated_w : vga_r_q;
        vga_g_d  = p_tick_w ? g_gated_w : vga_g_q;
        vga_b_d  = p_tick_w ? b_gated_w : vga_b_q;
        hs_out_d = p_tick_w ? hsync_q   : hs_out_q;
        vs_out_d = p_tick_w ? vsync_q   : vs_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r_q  <= '0;
            vga_g_q  <= '0;
            vga_b_q  <= '0;
            hs_out_q <= 1'b1;
            vs_out_q <= 1'b1;
        end else begin
            vga_r_q  <= vga_r_d;
            vga_g_q  <= vga_g_d;
            vga_b_q  <= vga_b_d;
            hs_out_q <= hs_out_d;
            vs_out_q <= vs_out_d;
        end
    end

    assign vid.vga_r   = vga_r_q;
    assign vid.vga_g   = vga_g_q;
    assign vid.vga_b   = vga_b_q;
    assign vid.hsync_n = hs_out_q;
    assign vid.vsync_n = vs_out_q;
`else
    assign vid.vga_r   = r_gated_w;
    assign vid.vga_g   = g_gated_w;
    assign vid.vga_b   = b_gated_w;
    assign vid.hsync_n = hsync_q;
    assign vid.vsync_n = vsync_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_core.sv
// ============================================================================
// Module      : tb_vga_sync_core
// Description : Scoreboard bench for vga_sync_core with a narrow line and the
//               full default vertical timing, so a whole frame fits the run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_core;
    localparam int D  = 2;
    localparam int HD = 12, HF = 2, HS = 3, HB = 3;
    localparam int VD = 480, VF = 10, VS = 2, VB = 33;
    localparam int HT = HD + HF + HS + HB;   // 20
    localparam int VT = VD + VF + VS + VB;   // 525
    localparam int FT = HT * VT;             // pixels per frame

    typedef struct packed {
        logic [31:0] cyc;
        logic [11:0] x;
        logic [11:0] y;
        logic        pt;
        logic        von;
        logic        ft;
        logic        hs;
        logic        vs;
        logic [4:0]  r;
        logic [5:0]  g;
        logic [4:0]  b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   mode = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    vga_sync_core_if vif ();

    vga_sync_core #(
        .CLK_DIV(D), .H_DISPLAY(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_DISPLAY(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (vif.master)
    );

    always #5 clk = ~clk;

    // Renderer: mode 0 paints all-ones, mode 1 paints red only in column 10
    always_comb begin
        vif.rgb_r = (mode == 0 || vif.pixel_x == 12'd10) ? 5'd31 : 5'd0;
        vif.rgb_g = (mode == 0) ? 6'd63 : 6'd0;
        vif.rgb_b = (mode == 0) ? 5'd31 : 5'd0;
    end

    function automatic logic hs_of(input int x);
        return !(x >= HD + HF && x <= HD + HF + HS - 1);
    endfunction

    function automatic logic vs_of(input int y);
        return !(y >= VD + VF && y <= VD + VF + VS - 1);
    endfunction

    function automatic logic [15:0] rgb_of(input int x, input int y);
        logic [15:0] v;
        v = 16'h0;
        if (x < HD && y < VD) begin
            v[15:11] = (mode == 0 || x == 10) ? 5'd31 : 5'd0;
            v[10:5]  = (mode == 0) ? 6'd63 : 6'd0;
            v[4:0]   = (mode == 0) ? 5'd31 : 5'd0;
        end
        return v;
    endfunction

    // Closed form: after c clock edges from reset release, c/D pixel ticks have happened
    function automatic exp_t exp_at(input int c);
        exp_t e;
        int n, p, x, y, pp;
        logic [15:0] col;
        n = c / D;
        p = n % FT;
        x = p % HT;
        y = p / HT;
        e.cyc = 32'(c);
        e.x   = 12'(x);
        e.y   = 12'(y);
        e.pt  = (c % D) == (D - 1);
        e.von = (x < HD) && (y < VD);
        e.ft  = e.pt && (x == HT - 1) && (y == VT - 1);
`ifdef VGA_SYNC_OUT_REG_EN
        if (n == 0) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
            col  = 16'h0;
        end else begin
            pp   = (n - 1) % FT;
            e.hs = hs_of(pp % HT);
            e.vs = vs_of(pp / HT);
            col  = rgb_of(pp % HT, pp / HT);
        end
`else
        pp   = p;
        e.hs = hs_of(x);
        e.vs = vs_of(y);
        col  = rgb_of(x, y);
`endif
        e.r = col[15:11];
        e.g = col[10:5];
        e.b = col[4:0];
        return e;
    endfunction

    exp_t e_mon, g_mon;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e_mon = q.pop_front();
            g_mon.cyc = e_mon.cyc;
            g_mon.x   = vif.pixel_x;
            g_mon.y   = vif.pixel_y;
            g_mon.pt  = vif.p_tick;
            g_mon.von = vif.video_on;
            g_mon.ft  = vif.frame_tick;
            g_mon.hs  = vif.hsync_n;
            g_mon.vs  = vif.vsync_n;
            g_mon.r   = vif.vga_r;
            g_mon.g   = vif.vga_g;
            g_mon.b   = vif.vga_b;
            tests++;
            if (g_mon !== e_mon) begin
                fails++;
                $display("FAIL raster cyc=%0d: got x=%0d y=%0d pt=%b von=%b ft=%b hs=%b vs=%b rgb=%h/%h/%h, need x=%0d y=%0d pt=%b von=%b ft=%b hs=%b vs=%b rgb=%h/%h/%h",
                         e_mon.cyc, g_mon.x, g_mon.y, g_mon.pt, g_mon.von, g_mon.ft, g_mon.hs, g_mon.vs,
                         g_mon.r, g_mon.g, g_mon.b, e_mon.x, e_mon.y, e_mon.pt, e_mon.von, e_mon.ft,
                         e_mon.hs, e_mon.vs, e_mon.r, e_mon.g, e_mon.b);
            end
        end
    end

    initial begin
        int c_rst;
        c_rst = D * (FT + 490 * HT + 15);  // second frame, inside hsync and vsync

        // Reset state
        rst_n = 1'b0;
        mode  = 0;
        repeat (3) @(posedge clk);
        q.push_back(exp_at(0));
        @(negedge clk);
        #1 rst_n = 1'b1;

        // One full frame and well into the next, every cycle scored
        for (int c = 1; c < c_rst; c++) begin
            @(posedge clk);
            q.push_back(exp_at(c));
        end

        // Asynchronous reset between edges: outputs must clear before the next edge
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.push_back(exp_at(0));
        @(negedge clk);
        @(posedge clk);
        mode = 1;
        q.push_back(exp_at(0));
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Clean restart with a single lit column
        for (int c = 1; c <= D * HT * 3 + 5; c++) begin
            @(posedge clk);
            q.push_back(exp_at(c));
        end

        repeat (2) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending entries, need 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/vga_sync_core.md
# vga_sync_core

Timing generator and output stage for the VGA video path. It divides the system clock into a pixel-rate enable and scans a configurable H/V raster. It drives `pixel_x`, `pixel_y` and `video_on` into the pixel-generation stage (ball/box renderers) and receives that stage's 5/6/5 RGB back. It then drives the blanked RGB and active-low sync pins at the connector.

## Interface
- `CLK_DIV`, 2, system clocks per pixel (≥1); 2 gives 25 MHz pixels from 50 MHz
- `H_DISPLAY`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_DISPLAY`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)

Ports:
- `clk` in 1: system clock; the block has one clock
- `rst_n` in 1: reset, asynchronous and active-low
- `rgb_r` in 5, `rgb_g` in 6, `rgb_b` in 5: pixel colour from the renderer for the current `pixel_x`/`pixel_y`
- `p_tick` out 1: one-`clk` pixel enable
- `pixel_x` out 12, `pixel_y` out 12: current scan position
- `video_on` out 1: high inside the visible area
- `frame_tick` out 1: one-`clk` pulse on the last pixel of each frame
- `hsync_n` out 1, `vsync_n` out 1: sync outputs, active low
- `vga_r` out 5, `vga_g` out 6, `vga_b` out 5: colour to the DAC

## Operation
- H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP (525). Both totals must be < 4096.
- Divider: the `div` counter runs 0..CLK_DIV-1 and wraps. `p_tick` = (div == CLK_DIV-1). When CLK_DIV = 1, `p_tick` is held at 1.
- `pixel_x` register: on `p_tick` it increments, and wraps H_TOTAL-1 → 0.
- `pixel_y` register: it increments only on `p_tick` while `pixel_x` == H_TOTAL-1, and wraps V_TOTAL-1 → 0.
- Both counters hold between ticks.
- `video_on` = (`pixel_x` < H_DISPLAY) && (`pixel_y` < V_DISPLAY), decoded from the registered counters.
- `hsync_n` and `vsync_n` are registers, each loaded with the decode of the counter's next value on the same edge, so they stay aligned with the counters and are glitch-free.
  - `hsync_n` = 0 iff H_DISPLAY+H_FP ≤ x ≤ H_DISPLAY+H_FP+H_SYNC-1 (656..751).
  - `vsync_n` = 0 iff V_DISPLAY+V_FP ≤ y ≤ V_DISPLAY+V_FP+V_SYNC-1 (490..491).
- `frame_tick` = `p_tick` && x == H_TOTAL-1 && y == V_TOTAL-1 (combinational).
- Blanking: RGB outputs are forced to 0 whenever the (aligned) video_on is 0.
- Mid-operation reset: the raster restarts at (0,0) with the divider at 0. There is no partial-line recovery.

## Timing
- Reset values:
  - `div` = 0, `pixel_x` = 0, `pixel_y` = 0
  - `hsync_n` = 1, `vsync_n` = 1
  - `p_tick` = 0 (CLK_DIV > 1), `video_on` = 1, `frame_tick` = 0, `vga_*` = 0
- First `p_tick` arrives CLK_DIV `clk` cycles after reset release. After that it repeats every CLK_DIV cycles.
- The counters change on the `clk` edge at which `p_tick` is high.
- Line period = H_TOTAL×CLK_DIV clk (1600). Frame period = H_TOTAL×V_TOTAL×CLK_DIV clk (840 000).
- The renderer must present RGB combinationally from `pixel_x`/`pixel_y` within the same pixel.
- `pixel_y` = 500 lies inside vertical blanking for the default parameters. Downstream logic uses it as a once-per-frame update point; it must remain in blanking for every parameter set (V_DISPLAY ≤ 500 < V_TOTAL).

## Configuration
- Macro `VGA_SYNC_OUT_REG_EN`.
- Defined:
  - `vga_r/g/b`, `hsync_n` and `vsync_n` pass through an output register stage, loaded on `p_tick`. RGB is loaded with the video_on-gated value.
  - Pins lag `pixel_x` by exactly one pixel; syncs are delayed equally, so colour and sync stay aligned.
  - Reset values: RGB = 0, syncs = 1.
- Undefined:
  - `vga_* = video_on ? rgb_* : 0` combinationally.
  - Syncs are driven directly from the sync registers with zero pixel lag.

## Test plan
- **Divider:** reset, release, default params → `p_tick` high on clk cycles 2, 4, 6…; `pixel_x` reads 1 after the first tick; `frame_tick` absent for the first 839 999 cycles and present on cycle 840 000.
- **Horizontal:** count ticks on line 0 → `hsync_n` = 0 exactly for x = 656..751 (96 pixels); `video_on` falls at x = 640; `pixel_x` wraps 799 → 0 and `pixel_y` becomes 1 on the same edge.
- **Vertical:** run one frame → `vsync_n` = 0 for lines 490–491 only (1600 clk each); `video_on` = 0 for all of y = 480..524; y wraps 524 → 0 coincident with `frame_tick`.
- **Blanking:** `rgb_*` tied to all-ones → `vga_*` all-ones only while `video_on`; 0 at x = 640..799 and at y ≥ 480.
- **Mid-frame reset:** assert `rst_n` at x = 300, y = 200 → counters 0 and `hsync_n`/`vsync_n` = 1 immediately, asynchronously; clean frame restart after release.
- **Output register (`VGA_SYNC_OUT_REG_EN` defined):** `rgb_r` = 31 only at x = 10 → `vga_r` = 31 only while `pixel_x` = 11; `hsync_n` falls when `pixel_x` = 657.
